// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;

   // Frame parser states; CHECK is only entered when the checksum trailer is built in
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LEN_HI = 3'd1,
      LEN_LO = 3'd2,
      DATA   = 3'd3,
      CHECK  = 3'd4,
      DONE   = 3'd5,
      ERROR  = 3'd6
   } state_t;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam int         LEN_WIDTH = 16;

endpackage

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Parses a framed byte stream (SYNC, LEN_HI, LEN_LO, payload[, CHK]) arriving
// over a valid/ready link and writes payload byte k to memory address k.
// The CPU is held in reset until a frame has loaded cleanly.
// Optional feature macro: LOADER_CHECKSUM_EN adds an XOR checksum trailer byte
// that must match the running XOR of the payload before the load is accepted.
module imem_loader
   import loader_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 8,
   parameter int MEM_BYTES     = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_WIDTH-1:0]    in_data,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   output logic                     cpu_hold,
   output logic                     done,
   output logic                     error
);

   state_t               state;
   logic [LEN_WIDTH-1:0] len_reg;
   logic [LEN_WIDTH-1:0] count;
   logic [LEN_WIDTH-1:0] len_full;
   logic                 xfer;
   logic                 is_sync;
   logic                 len_bad;
   logic                 last_byte;

`ifdef LOADER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] chk;
`endif

   // The only state that refuses bytes is the one-cycle DONE pulse
   assign in_ready = (state != DONE);

   assign xfer      = in_valid & in_ready;
   assign is_sync   = (in_data == SYNC_BYTE);
   assign len_full  = {len_reg[LEN_WIDTH-1:8], in_data[7:0]};
   assign len_bad   = (len_full == '0) || (32'(len_full) > 32'(MEM_BYTES));
   assign last_byte = (count == (len_reg - 16'd1));

   // Frame parser FSM with registered write port and status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         len_reg   <= '0;
         count     <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_hold  <= 1'b1;
         done      <= 1'b0;
         error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         chk       <= '0;
`endif
      end else begin
         mem_we <= 1'b0;
         done   <= 1'b0;
         case (state)
            IDLE: begin
               if (xfer && is_sync) begin
                  state    <= LEN_HI;
                  error    <= 1'b0;
                  cpu_hold <= 1'b1;
               end
            end
            LEN_HI: begin
               if (xfer) begin
                  len_reg[LEN_WIDTH-1:8] <= in_data[7:0];
                  state                  <= LEN_LO;
               end
            end
            LEN_LO: begin
               if (xfer) begin
                  len_reg <= len_full;
                  if (len_bad) begin
                     state    <= ERROR;
                     error    <= 1'b1;
                     cpu_hold <= 1'b1;
                  end else begin
                     state <= DATA;
                     count <= '0;
`ifdef LOADER_CHECKSUM_EN
                     chk   <= '0;
`endif
                  end
               end
            end
            DATA: begin
               if (xfer) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= ADDRESS_WIDTH'(count);
                  mem_wdata <= in_data;
                  count     <= count + 16'd1;
`ifdef LOADER_CHECKSUM_EN
                  chk       <= chk ^ in_data;
                  if (last_byte) begin
                     state <= CHECK;
                  end
`else
                  if (last_byte) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end
`endif
               end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
               if (xfer) begin
                  if (in_data == chk) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     state    <= ERROR;
                     error    <= 1'b1;
                     cpu_hold <= 1'b1;
                  end
               end
            end
`endif
            DONE: begin
               state <= IDLE;
            end
            ERROR: begin
               if (xfer && is_sync) begin
                  state <= LEN_HI;
                  error <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (directed frames, works with or without
// LOADER_CHECKSUM_EN defined).
module tb_imem_loader;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        cpu_hold;
   logic        done;
   logic        error;

   int total;
   int bad;

   logic [31:0] wr_addr[$];
   logic [7:0]  wr_data[$];
   int          done_cnt;
   int          wr_viol;
   int          done_hold_bad;
   logic        prev_hold;

   imem_loader #(
      .ADDRESS_WIDTH(32),
      .DATA_WIDTH   (8),
      .MEM_BYTES    (1024)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .cpu_hold (cpu_hold),
      .done     (done),
      .error    (error)
   );

   // 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Write/done monitor: a write seen after an edge must come from a byte transferred on that edge
   always @(posedge clk) begin
      logic       xfer_pre;
      logic [7:0] data_pre;
      xfer_pre = in_valid && in_ready && !rst;
      data_pre = in_data;
      #1;
      if (mem_we) begin
         if (!xfer_pre || (mem_wdata !== data_pre)) wr_viol++;
         wr_addr.push_back(mem_addr);
         wr_data.push_back(mem_wdata);
      end
      if (done === 1'b1) begin
         done_cnt++;
         if (!(cpu_hold === 1'b0 && prev_hold === 1'b1)) done_hold_bad++;
      end
      prev_hold = cpu_hold;
   end

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      done_cnt      = 0;
      wr_viol       = 0;
      done_hold_bad = 0;
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int waited;
      @(negedge clk);
      if (gap > 0) begin
         in_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = b;
      waited   = 0;
      while (!in_ready && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 10) begin
         total++;
         bad++;
         $display("[TB] FAIL in_ready_timeout: got in_ready=%b want 1 within 10 cycles", in_ready);
      end
      @(posedge clk);
   endtask

   task automatic send_frame(input logic [7:0] payload[$], input bit gaps);
      logic [15:0] len;
      logic [7:0]  x;
      int          idx;
      len = 16'(payload.size());
      x   = 8'h00;
      idx = 0;
      send_byte(8'hA5, 0);
      send_byte(len[15:8], gaps ? 2 : 0);
      send_byte(len[7:0], gaps ? 1 : 0);
      foreach (payload[i]) begin
         x = x ^ payload[i];
         send_byte(payload[i], gaps ? (idx % 3) : 0);
         idx++;
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(x, gaps ? 1 : 0);
`endif
      idle(4);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(negedge clk);
      if (mem_we !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_we: got %b want 0", mem_we); end
      total++;
      if (mem_addr !== 32'd0) begin bad++; $display("[TB] FAIL reset_mem_addr: got %h want 0", mem_addr); end
      total++;
      if (mem_wdata !== 8'd0) begin bad++; $display("[TB] FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
      total++;
      if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b want 0", done); end
      total++;
      if (error !== 1'b0) begin bad++; $display("[TB] FAIL reset_error: got %b want 0", error); end
      total++;
      if (cpu_hold !== 1'b1) begin bad++; $display("[TB] FAIL reset_cpu_hold: got %b want 1", cpu_hold); end
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
      total++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_basic_writes(input string tag);
      logic [7:0] exp_d[4];
      exp_d = '{8'h13, 8'h05, 8'h00, 8'h00};
      if (wr_addr.size() !== 4) begin bad++; $display("[TB] FAIL %s_write_count: got %0d want 4", tag, wr_addr.size()); end
      total++;
      for (int i = 0; i < 4; i++) begin
         if (i < wr_addr.size()) begin
            if (wr_addr[i] !== 32'(i)) begin bad++; $display("[TB] FAIL %s_addr%0d: got %0d want %0d", tag, i, wr_addr[i], i); end
            total++;
            if (wr_data[i] !== exp_d[i]) begin bad++; $display("[TB] FAIL %s_data%0d: got %h want %h", tag, i, wr_data[i], exp_d[i]); end
            total++;
         end
      end
      if (wr_viol !== 0) begin bad++; $display("[TB] FAIL %s_write_timing: got %0d bad writes want 0", tag, wr_viol); end
      total++;
      if (done_cnt !== 1) begin bad++; $display("[TB] FAIL %s_done_count: got %0d want 1", tag, done_cnt); end
      total++;
      if (done_hold_bad !== 0) begin bad++; $display("[TB] FAIL %s_hold_at_done: got %0d misaligned want 0", tag, done_hold_bad); end
      total++;
      if (cpu_hold !== 1'b0) begin bad++; $display("[TB] FAIL %s_hold_after: got %b want 0", tag, cpu_hold); end
      total++;
      if (error !== 1'b0) begin bad++; $display("[TB] FAIL %s_error: got %b want 0", tag, error); end
      total++;
   endtask

   task automatic test_basic();
      logic [7:0] p[$];
      p = '{8'h13, 8'h05, 8'h00, 8'h00};
      clear_log();
      send_frame(p, 1'b0);
      check_basic_writes("basic");
   endtask

   task automatic test_gaps();
      logic [7:0] p[$];
      p = '{8'h13, 8'h05, 8'h00, 8'h00};
      clear_log();
      send_frame(p, 1'b1);
      check_basic_writes("gaps");
   endtask

   task automatic test_len_errors();
      clear_log();
      send_byte(8'hA5, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      idle(3);
      if (error !== 1'b1) begin bad++; $display("[TB] FAIL len0_error: got %b want 1", error); end
      total++;
      if (cpu_hold !== 1'b1) begin bad++; $display("[TB] FAIL len0_hold: got %b want 1", cpu_hold); end
      total++;
      send_byte(8'hA5, 0);
      idle(1);
      if (error !== 1'b0) begin bad++; $display("[TB] FAIL sync_clears_error: got %b want 0", error); end
      total++;
      send_byte(8'h04, 0);
      send_byte(8'h01, 0);
      idle(3);
      if (error !== 1'b1) begin bad++; $display("[TB] FAIL len1025_error: got %b want 1", error); end
      total++;
      if (cpu_hold !== 1'b1) begin bad++; $display("[TB] FAIL len1025_hold: got %b want 1", cpu_hold); end
      total++;
      if (wr_addr.size() !== 0) begin bad++; $display("[TB] FAIL len_err_writes: got %0d want 0", wr_addr.size()); end
      total++;
      if (done_cnt !== 0) begin bad++; $display("[TB] FAIL len_err_done: got %0d want 0", done_cnt); end
      total++;
   endtask

`ifdef LOADER_CHECKSUM_EN
   task automatic test_checksum();
      clear_log();
      send_byte(8'hA5, 0);
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      send_byte(8'hAA, 0);
      send_byte(8'h55, 0);
      send_byte(8'h00, 0);
      idle(3);
      if (wr_addr.size() !== 2) begin bad++; $display("[TB] FAIL chk_bad_writes: got %0d want 2", wr_addr.size()); end
      total++;
      if (error !== 1'b1) begin bad++; $display("[TB] FAIL chk_bad_error: got %b want 1", error); end
      total++;
      if (done_cnt !== 0) begin bad++; $display("[TB] FAIL chk_bad_done: got %0d want 0", done_cnt); end
      total++;
      clear_log();
      send_byte(8'hA5, 0);
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      send_byte(8'hAA, 0);
      send_byte(8'h55, 0);
      send_byte(8'hFF, 0);
      idle(3);
      if (error !== 1'b0) begin bad++; $display("[TB] FAIL chk_good_error: got %b want 0", error); end
      total++;
      if (done_cnt !== 1) begin bad++; $display("[TB] FAIL chk_good_done: got %0d want 1", done_cnt); end
      total++;
      if (wr_addr.size() !== 2) begin bad++; $display("[TB] FAIL chk_good_writes: got %0d want 2", wr_addr.size()); end
      total++;
   endtask
`endif

   task automatic test_leading_junk();
      logic [7:0] p[$];
      p = '{8'hDE, 8'hAD};
      clear_log();
      send_byte(8'h00, 0);
      send_byte(8'hFF, 0);
      idle(2);
      if (wr_addr.size() !== 0) begin bad++; $display("[TB] FAIL junk_writes: got %0d want 0", wr_addr.size()); end
      total++;
      send_frame(p, 1'b0);
      if (wr_addr.size() !== 2) begin bad++; $display("[TB] FAIL junk_frame_writes: got %0d want 2", wr_addr.size()); end
      total++;
      if (wr_addr.size() == 2) begin
         if (wr_addr[0] !== 32'd0 || wr_data[0] !== 8'hDE) begin bad++; $display("[TB] FAIL junk_w0: got %h@%0d want de@0", wr_data[0], wr_addr[0]); end
         total++;
         if (wr_addr[1] !== 32'd1 || wr_data[1] !== 8'hAD) begin bad++; $display("[TB] FAIL junk_w1: got %h@%0d want ad@1", wr_data[1], wr_addr[1]); end
         total++;
      end
      if (done_cnt !== 1) begin bad++; $display("[TB] FAIL junk_done: got %0d want 1", done_cnt); end
      total++;
   endtask

   task automatic test_max_len();
      logic [7:0] p[$];
      for (int i = 0; i < 1024; i++) p.push_back(8'(i) ^ 8'h5A);
      clear_log();
      send_frame(p, 1'b0);
      if (wr_addr.size() !== 1024) begin bad++; $display("[TB] FAIL max_writes: got %0d want 1024", wr_addr.size()); end
      total++;
      if (wr_addr.size() == 1024) begin
         if (wr_addr[1023] !== 32'd1023 || wr_data[1023] !== 8'hA5) begin bad++; $display("[TB] FAIL max_last: got %h@%0d want a5@1023", wr_data[1023], wr_addr[1023]); end
         total++;
         if (wr_addr[256] !== 32'd256 || wr_data[256] !== 8'h5A) begin bad++; $display("[TB] FAIL max_mid: got %h@%0d want 5a@256", wr_data[256], wr_addr[256]); end
         total++;
      end
      if (done_cnt !== 1) begin bad++; $display("[TB] FAIL max_done: got %0d want 1", done_cnt); end
      total++;
      if (wr_viol !== 0) begin bad++; $display("[TB] FAIL max_timing: got %0d want 0", wr_viol); end
      total++;
   endtask

   task automatic test_reset_mid();
      logic [7:0] p[$];
      p = '{8'h77};
      clear_log();
      send_byte(8'hA5, 0);
      send_byte(8'h00, 0);
      send_byte(8'h04, 0);
      send_byte(8'h13, 0);
      send_byte(8'h05, 0);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      if (mem_we !== 1'b0) begin bad++; $display("[TB] FAIL midrst_mem_we: got %b want 0", mem_we); end
      total++;
      if (mem_addr !== 32'd0) begin bad++; $display("[TB] FAIL midrst_mem_addr: got %0d want 0", mem_addr); end
      total++;
      if (mem_wdata !== 8'd0) begin bad++; $display("[TB] FAIL midrst_mem_wdata: got %h want 0", mem_wdata); end
      total++;
      if (cpu_hold !== 1'b1) begin bad++; $display("[TB] FAIL midrst_hold: got %b want 1", cpu_hold); end
      total++;
      if (wr_addr.size() !== 2) begin bad++; $display("[TB] FAIL midrst_partial: got %0d want 2", wr_addr.size()); end
      total++;
      @(negedge clk);
      rst = 1'b0;
      clear_log();
      send_frame(p, 1'b0);
      if (wr_addr.size() !== 1) begin bad++; $display("[TB] FAIL fresh_writes: got %0d want 1", wr_addr.size()); end
      total++;
      if (wr_addr.size() == 1) begin
         if (wr_addr[0] !== 32'd0 || wr_data[0] !== 8'h77) begin bad++; $display("[TB] FAIL fresh_w0: got %h@%0d want 77@0", wr_data[0], wr_addr[0]); end
         total++;
      end
      if (done_cnt !== 1) begin bad++; $display("[TB] FAIL fresh_done: got %0d want 1", done_cnt); end
      total++;
   endtask

   // Run every scenario in order, then print the summary
   initial begin
      total     = 0;
      bad       = 0;
      prev_hold = 1'b1;
      clear_log();
      test_reset();
      test_basic();
      test_gaps();
      test_len_errors();
`ifdef LOADER_CHECKSUM_EN
      test_checksum();
`endif
      test_leading_junk();
      test_max_len();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
